comb_sweep_tester: RTL

Sequential exhaustive tester for the team's six-input / five-output combinational function unit. It drives all 64 input vectors in order onto the unit and waits a programmable settle time per vector. It then compares the unit's five outputs against an internal golden model and records the error count, the first failing vector, and a 16-bit MISR signature of the observed responses. It sits between a test controller (start/done) and the function unit under test.

---
 rtl/comb_sweep_tester_pkg.sv | 13 +
 rtl/comb_sweep_tester_golden.sv | 15 +
 rtl/comb_sweep_tester.sv | 101 ++++++++++
 3 files changed

// File: rtl/comb_sweep_tester_pkg.sv
// comb_sweep_tester_pkg: shared state encoding, widths, MISR constants and MISR step
package comb_sweep_tester_pkg;
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;
   localparam int VEC_W = 6;
   localparam int Y_W   = 5;
   localparam int SIG_W = 16;
   localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;
   localparam logic [SIG_W-1:0] MISR_SEED = 16'hFFFF;
   localparam logic [VEC_W-1:0] LAST_VEC  = 6'd63;
   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig, input logic [Y_W-1:0] y);
      return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0) ^ {{(SIG_W-Y_W){1'b0}}, y};
   endfunction
endpackage

// File: rtl/comb_sweep_tester_golden.sv
// comb_golden: reference model of the six-input / five-output function unit
module comb_golden
   import comb_sweep_tester_pkg::*;
(
   input  logic [VEC_W-1:0] i_vec,
   output logic [Y_W-1:0]   o_y
);
   logic w_a, w_b, w_c, w_d, w_e, w_f;
   assign {w_a, w_b, w_c, w_d, w_e, w_f} = i_vec;
   assign o_y[4] = (w_a & w_b) | (w_c & w_d);
   assign o_y[3] = ((w_a & w_b & w_c) | (w_d & w_e)) & w_f;
   assign o_y[2] = ~((w_a | ~w_b) & ((w_c & w_d) | w_e));
   assign o_y[1] = (~w_a & w_d) | (w_b & w_d);
   assign o_y[0] = (w_c & ~w_d) | (~w_b & ~w_d) | (w_a & w_b & ~w_c & w_d);
endmodule

// File: rtl/comb_sweep_tester.sv
// comb_sweep_tester: sweeps all 64 input vectors, checks responses, keeps error stats and MISR
module comb_sweep_tester
   import comb_sweep_tester_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [VEC_W-1:0] dut_in,
   input  logic [Y_W-1:0]   dut_y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [6:0]       err_count,
   output logic [VEC_W-1:0] first_fail_vec,
   output logic [Y_W-1:0]   first_fail_y,
   output logic [SIG_W-1:0] signature
);
   state_t           r_state, w_next;
   logic [3:0]       r_cnt;
   logic [VEC_W-1:0] r_vec;
   logic [6:0]       r_err;
   logic [VEC_W-1:0] r_ffv;
   logic [Y_W-1:0]   r_ffy;
   logic [SIG_W-1:0] r_sig;
   logic             r_busy, r_done;
   logic [Y_W-1:0]   w_exp;
   logic             w_accept, w_settle_end, w_last, w_mismatch;

   comb_golden u_golden (.i_vec(r_vec), .o_y(w_exp));

   assign w_accept     = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_settle_end = r_cnt == 4'(SETTLE_CYCLES - 1);
   assign w_last       = r_vec == LAST_VEC;
   assign w_mismatch   = dut_y != w_exp;

   assign dut_in         = r_vec;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_done && (r_err == '0);
   assign err_count      = r_err;
   assign first_fail_vec = r_ffv;
   assign first_fail_y   = r_ffy;
   assign signature      = r_sig;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // next-state: start accepted only when idle or finished, one CHECK cycle per vector
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start) w_next = S_SETTLE;
         S_SETTLE:       if (w_settle_end) w_next = S_CHECK;
         S_CHECK:        w_next = w_last ? S_DONE : S_SETTLE;
         default:        w_next = S_IDLE;
      endcase
   end

   // datapath: stimulus, settle counter, error capture, MISR and registered status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_vec  <= '0;
         r_err  <= '0;
         r_ffv  <= '0;
         r_ffy  <= '0;
         r_sig  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_next == S_SETTLE) || (w_next == S_CHECK);
         r_done <= w_next == S_DONE;
         if (w_accept) begin
            r_cnt <= '0;
            r_vec <= '0;
            r_err <= '0;
            r_ffv <= '0;
            r_ffy <= '0;
            r_sig <= MISR_SEED;
         end else if (r_state == S_SETTLE) begin
            r_cnt <= w_settle_end ? 4'd0 : r_cnt + 4'd1;
         end else if (r_state == S_CHECK) begin
            r_cnt <= '0;
            r_sig <= misr_step(r_sig, dut_y);
            if (w_mismatch) begin
               r_err <= r_err + 7'd1;
               if (r_err == '0) begin
                  r_ffv <= r_vec;
                  r_ffy <= dut_y;
               end
            end
            if (!w_last) r_vec <= r_vec + VEC_W'(1);
         end
      end
   end
endmodule
